// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, jump/branch squash,
// memory-wait freeze and halt drain for the 5-stage core.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rs_IFID,
    input  logic [2:0]        rt_IFID,
    input  logic              rsUsed_IFID,
    input  logic              rtUsed_IFID,
    input  logic              MemRead_IDEX,
    input  logic [2:0]        WrR_IDEX,
    input  logic              Jump_IDEX,
    input  logic              takeBranch_EXMEM,
    input  logic              halt_IDEX,
    input  logic              imemStall,
    input  logic              dmemStall,
    output logic              pcEn,
    output logic              ifidEn,
    output logic              ifidFlush,
    output logic              stallCtrl,
    output logic              jumpFlush,
    output logic              pipeEn,
    output logic              haltDone,
    output logic [2:0]        state,
    output logic [PERF_W-1:0] stallCnt
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        MEMWAIT = 3'd1,
        DRAIN   = 3'd2,
        HALTED  = 3'd3
    } state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              mem_stall;
    logic              lu_haz;

    assign mem_stall = imemStall | dmemStall;
    assign lu_haz    = MemRead_IDEX &
                       ((rsUsed_IFID & (rs_IFID == WrR_IDEX)) |
                        (rtUsed_IFID & (rt_IFID == WrR_IDEX)));
    assign state     = state_q;

    // State, drain counter, sticky halt flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            haltDone <= 1'b0;
            stallCnt <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            haltDone <= haltDone | (state_n == HALTED);
            if (!pcEn && (stallCnt != {PERF_W{1'b1}}))
                stallCnt <= stallCnt + PERF_W'(1);
        end
    end

    // Next-state and combinational pipe controls
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        pcEn      = 1'b1;
        ifidEn    = 1'b1;
        ifidFlush = 1'b0;
        stallCtrl = 1'b0;
        jumpFlush = 1'b0;
        pipeEn    = 1'b1;

        case (state_q)
            // MEMWAIT releases into RUN priorities on its first quiet cycle
            RUN, MEMWAIT: begin
                state_n = RUN;
                if (mem_stall) begin
                    pcEn    = 1'b0;
                    ifidEn  = 1'b0;
                    pipeEn  = 1'b0;
                    state_n = MEMWAIT;
                end else if (takeBranch_EXMEM) begin
                    ifidFlush = 1'b1;
                    stallCtrl = 1'b1;
                end else if (Jump_IDEX) begin
                    ifidFlush = 1'b1;
                    jumpFlush = 1'b1;
                end else if (halt_IDEX) begin
                    pcEn      = 1'b0;
                    ifidFlush = 1'b1;
                    state_n   = DRAIN;
                    cnt_n     = CNT_W'(DRAIN_CYCLES - 1);
                end else if (lu_haz) begin
                    stallCtrl = 1'b1;
                    pcEn      = 1'b0;
                    ifidEn    = 1'b0;
                end
            end
            DRAIN: begin
                pcEn      = 1'b0;
                ifidEn    = 1'b0;
                ifidFlush = 1'b1;
                stallCtrl = 1'b1;
                pipeEn    = ~mem_stall;
                if (!mem_stall) begin
                    if (cnt_q == '0)
                        state_n = HALTED;
                    else
                        cnt_n = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                pcEn   = 1'b0;
                ifidEn = 1'b0;
                pipeEn = 1'b0;
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs_IFID, rt_IFID, WrR_IDEX;
    logic        rsUsed_IFID, rtUsed_IFID, MemRead_IDEX;
    logic        Jump_IDEX, takeBranch_EXMEM, halt_IDEX;
    logic        imemStall, dmemStall;
    logic        pcEn, ifidEn, ifidFlush, stallCtrl, jumpFlush, pipeEn, haltDone;
    logic [2:0]  state;
    logic [15:0] stallCnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2), .PERF_W(16)) dut (
        .clk(clk), .rst(rst),
        .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
        .rsUsed_IFID(rsUsed_IFID), .rtUsed_IFID(rtUsed_IFID),
        .MemRead_IDEX(MemRead_IDEX), .WrR_IDEX(WrR_IDEX),
        .Jump_IDEX(Jump_IDEX), .takeBranch_EXMEM(takeBranch_EXMEM),
        .halt_IDEX(halt_IDEX), .imemStall(imemStall), .dmemStall(dmemStall),
        .pcEn(pcEn), .ifidEn(ifidEn), .ifidFlush(ifidFlush),
        .stallCtrl(stallCtrl), .jumpFlush(jumpFlush), .pipeEn(pipeEn),
        .haltDone(haltDone), .state(state), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_IFID = 3'd0; rt_IFID = 3'd0; WrR_IDEX = 3'd0;
        rsUsed_IFID = 1'b0; rtUsed_IFID = 1'b0; MemRead_IDEX = 1'b0;
        Jump_IDEX = 1'b0; takeBranch_EXMEM = 1'b0; halt_IDEX = 1'b0;
        imemStall = 1'b0; dmemStall = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (stallCnt !== 16'd0) begin errors++; $display("FAIL reset_stallCnt got %0d want 0", stallCnt); end
        checks++; if (haltDone !== 1'b0) begin errors++; $display("FAIL reset_haltDone got %0b want 0", haltDone); end
        checks++; if ({pcEn, ifidEn, pipeEn} !== 3'b111) begin errors++; $display("FAIL reset_enables got %b want 111", {pcEn, ifidEn, pipeEn}); end
        checks++; if ({ifidFlush, stallCtrl, jumpFlush} !== 3'b000) begin errors++; $display("FAIL reset_flush got %b want 000", {ifidFlush, stallCtrl, jumpFlush}); end
    endtask

    task automatic test_load_use();
        do_reset();
        MemRead_IDEX = 1'b1; WrR_IDEX = 3'd3; rs_IFID = 3'd3; rsUsed_IFID = 1'b1;
        #1;
        checks++; if ({stallCtrl, pcEn, ifidEn, pipeEn} !== 4'b1001) begin errors++; $display("FAIL lu_rs got %b want 1001", {stallCtrl, pcEn, ifidEn, pipeEn}); end
        tick();
        MemRead_IDEX = 1'b0;
        #1;
        checks++; if ({stallCtrl, pcEn, ifidEn} !== 3'b011) begin errors++; $display("FAIL lu_clear got %b want 011", {stallCtrl, pcEn, ifidEn}); end
        checks++; if (stallCnt !== 16'd1) begin errors++; $display("FAIL lu_stallCnt got %0d want 1", stallCnt); end
        MemRead_IDEX = 1'b1; rsUsed_IFID = 1'b0;
        #1;
        checks++; if ({stallCtrl, pcEn} !== 2'b01) begin errors++; $display("FAIL lu_rs_unused got %b want 01", {stallCtrl, pcEn}); end
        rt_IFID = 3'd3; rtUsed_IFID = 1'b1;
        #1;
        checks++; if ({stallCtrl, pcEn, ifidEn} !== 3'b100) begin errors++; $display("FAIL lu_rt got %b want 100", {stallCtrl, pcEn, ifidEn}); end
        WrR_IDEX = 3'd4;
        #1;
        checks++; if ({stallCtrl, pcEn} !== 2'b01) begin errors++; $display("FAIL lu_dest_diff got %b want 01", {stallCtrl, pcEn}); end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        takeBranch_EXMEM = 1'b1; Jump_IDEX = 1'b1;
        MemRead_IDEX = 1'b1; WrR_IDEX = 3'd2; rs_IFID = 3'd2; rsUsed_IFID = 1'b1;
        #1;
        checks++; if ({ifidFlush, stallCtrl, pcEn, jumpFlush} !== 4'b1110) begin errors++; $display("FAIL prio_branch got %b want 1110", {ifidFlush, stallCtrl, pcEn, jumpFlush}); end
        takeBranch_EXMEM = 1'b0;
        #1;
        checks++; if ({ifidFlush, jumpFlush, stallCtrl, pcEn} !== 4'b1101) begin errors++; $display("FAIL prio_jump_over_lu got %b want 1101", {ifidFlush, jumpFlush, stallCtrl, pcEn}); end
        clear_inputs();
    endtask

    task automatic test_jump();
        do_reset();
        Jump_IDEX = 1'b1;
        #1;
        checks++; if ({jumpFlush, ifidFlush, pcEn, stallCtrl} !== 4'b1110) begin errors++; $display("FAIL jump got %b want 1110", {jumpFlush, ifidFlush, pcEn, stallCtrl}); end
        tick();
        Jump_IDEX = 1'b0;
        #1;
        checks++; if ({jumpFlush, ifidFlush} !== 2'b00) begin errors++; $display("FAIL jump_after got %b want 00", {jumpFlush, ifidFlush}); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL jump_state got %0d want 0", state); end
    endtask

    task automatic test_halt();
        do_reset();
        halt_IDEX = 1'b1;
        #1;
        checks++; if ({pcEn, ifidFlush} !== 2'b01) begin errors++; $display("FAIL halt_issue got %b want 01", {pcEn, ifidFlush}); end
        tick();
        halt_IDEX = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) begin Jump_IDEX = 1'b1; takeBranch_EXMEM = 1'b1; end
            #1;
            checks++; if (state !== 3'd2) begin errors++; $display("FAIL halt_drain_state t+%0d got %0d want 2", k, state); end
            checks++; if ({pcEn, ifidEn, ifidFlush, stallCtrl, pipeEn, jumpFlush, haltDone} !== 7'b0011100) begin errors++; $display("FAIL halt_drain_out t+%0d got %b want 0011100", k, {pcEn, ifidEn, ifidFlush, stallCtrl, pipeEn, jumpFlush, haltDone}); end
            Jump_IDEX = 1'b0; takeBranch_EXMEM = 1'b0;
            tick();
        end
        #1;
        checks++; if (stallCnt !== 16'd4) begin errors++; $display("FAIL halt_stallCnt got %0d want 4", stallCnt); end
        for (int i = 0; i < 10; i++) begin
            checks++; if ({state, haltDone} !== 4'b0111) begin errors++; $display("FAIL halted_hold %0d got %b want 0111", i, {state, haltDone}); end
            checks++; if ({pcEn, ifidEn, pipeEn} !== 3'b000) begin errors++; $display("FAIL halted_en %0d got %b want 000", i, {pcEn, ifidEn, pipeEn}); end
            tick();
        end
        #1;
        checks++; if (stallCnt !== 16'd14) begin errors++; $display("FAIL halted_stallCnt got %0d want 14", stallCnt); end
    endtask

    task automatic test_halt_memstall();
        do_reset();
        halt_IDEX = 1'b1;
        tick();
        halt_IDEX = 1'b0;
        tick();
        dmemStall = 1'b1;
        #1;
        checks++; if ({state, pipeEn} !== 4'b0100) begin errors++; $display("FAIL drain_stall got %b want 0100", {state, pipeEn}); end
        tick();
        tick();
        dmemStall = 1'b0;
        for (int k = 4; k <= 5; k++) begin
            #1;
            checks++; if ({state, haltDone} !== 4'b0100) begin errors++; $display("FAIL drain_delay t+%0d got %b want 0100", k, {state, haltDone}); end
            tick();
        end
        #1;
        checks++; if ({state, haltDone} !== 4'b0111) begin errors++; $display("FAIL drain_halted t+6 got %b want 0111", {state, haltDone}); end
    endtask

    task automatic test_branch_cancels_halt();
        do_reset();
        halt_IDEX = 1'b1; takeBranch_EXMEM = 1'b1;
        #1;
        checks++; if ({pcEn, ifidFlush, stallCtrl} !== 3'b111) begin errors++; $display("FAIL bch_halt_out got %b want 111", {pcEn, ifidFlush, stallCtrl}); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({state, haltDone} !== 4'b0000) begin errors++; $display("FAIL bch_halt_state got %b want 0000", {state, haltDone}); end
    endtask

    task automatic test_memwait();
        do_reset();
        imemStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({pcEn, ifidEn, pipeEn, ifidFlush} !== 4'b0000) begin errors++; $display("FAIL memwait_en %0d got %b want 0000", i, {pcEn, ifidEn, pipeEn, ifidFlush}); end
            checks++; if (state !== ((i == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL memwait_state %0d got %0d want %0d", i, state, (i == 0) ? 0 : 1); end
            tick();
        end
        imemStall = 1'b0;
        #1;
        checks++; if ({state, pcEn, pipeEn} !== 5'b00111) begin errors++; $display("FAIL memwait_exit got %b want 00111", {state, pcEn, pipeEn}); end
        tick();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL memwait_run got %0d want 0", state); end
        checks++; if (stallCnt !== 16'd4) begin errors++; $display("FAIL memwait_stallCnt got %0d want 4", stallCnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        halt_IDEX = 1'b1;
        tick();
        halt_IDEX = 1'b0;
        #1;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rstmid_drain got %0d want 2", state); end
        tick();
        rst = 1'b1; imemStall = 1'b1; halt_IDEX = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if ({state, haltDone} !== 4'b0000) begin errors++; $display("FAIL rstmid_state got %b want 0000", {state, haltDone}); end
        checks++; if (stallCnt !== 16'd0) begin errors++; $display("FAIL rstmid_stallCnt got %0d want 0", stallCnt); end
        checks++; if ({pcEn, ifidEn, pipeEn} !== 3'b111) begin errors++; $display("FAIL rstmid_en got %b want 111", {pcEn, ifidEn, pipeEn}); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_priority();
        test_jump();
        test_halt();
        test_halt_memstall();
        test_branch_cancels_halt();
        test_memwait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
